// File: rtl/calc_display_pkg.sv
// Shared constants and helpers for the calculator's seven-segment display path.
// Segment patterns are active-high in bit order {g,f,e,d,c,b,a}.
package calc_display_pkg;

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    localparam logic [6:0] SEG_OFF   = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    // 0-9, then A b C d E F
    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Index of the highest nonzero nibble among the lowest n nibbles; 0 for a zero value.
    function automatic logic [3:0] msd_of(input logic [31:0] v, input int n);
        logic [3:0] m;
        m = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (i < n && v[4*i +: 4] != 4'd0) m = 4'(i);
        end
        return m;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seven_seg_decoder
    import calc_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_HEX[i_nibble];

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed 7-segment scanner: one digit lit per two scan ticks with a dark
// gap between digits, double-buffered value swapped only at frame wrap.
module display_scanner
    import calc_display_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter bit ACTIVE_LOW_SEG = 1'b1,
    parameter bit ACTIVE_LOW_AN  = 1'b1
) (
    input  logic                  clock_in,
    input  logic                  reset,
    input  logic                  scan_clk,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic                  negative,
    input  logic                  blank_zeros,
    input  logic                  load,
    output logic                  load_ack,
    output logic                  frame_done,
    output logic                  overflow,
    output logic [DIGITS-1:0]     anode,
    output logic [6:0]            segment
);

    localparam int                IDX_W     = $clog2(DIGITS);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [3:0]        MSD_TOP   = 4'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF    = ACTIVE_LOW_AN ? '1 : '0;
    localparam logic [6:0]        SEG_INACT = ACTIVE_LOW_SEG ? 7'h7F : SEG_OFF;

    logic                r_sync1, r_sync2, r_prev;
    logic                w_tick, w_wrap;
    state_t              r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;

    logic [4*DIGITS-1:0] r_pend_val, r_disp_val;
    logic                r_pend_neg, r_pend_blank, r_pend_flag;
    logic                r_disp_neg, r_disp_blank;

    logic [DIGITS-1:0]   r_anode, w_anode_d;
    logic [6:0]          r_segment, w_segment_d;
    logic                r_load_ack, r_frame_done, r_overflow;

    logic [3:0]          w_msd_disp, w_msd_pend, w_idx4, w_nib;
    logic [6:0]          w_dec;
    logic                w_is_minus, w_visible;

    // scan_clk is unrelated to clock_in timing, so it is synchronised before edge detection
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= scan_clk;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_tick = r_sync2 & ~r_prev;
    assign w_wrap = w_tick && (r_state == ST_SHOW) && (r_idx == IDX_LAST);

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_state <= ST_BLANK;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (w_tick) begin
            case (r_state)
                ST_BLANK: w_state_nxt = ST_SHOW;
                ST_SHOW: begin
                    w_state_nxt = ST_BLANK;
                    w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
                end
                default: w_state_nxt = ST_BLANK;
            endcase
        end
    end

    // Digit content for the current index, derived from the display buffer
    assign w_msd_disp = msd_of(32'(r_disp_val), DIGITS);
    assign w_msd_pend = msd_of(32'(r_pend_val), DIGITS);
    assign w_idx4     = 4'(r_idx);

    always_comb begin
        w_nib = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) w_nib = r_disp_val[4*i +: 4];
        end
    end

    seven_seg_decoder u_dec (
        .i_nibble (w_nib),
        .o_seg    (w_dec)
    );

    // The sign slot sits just above the MSD and stays lit even when blanking is off
    assign w_is_minus = r_disp_neg && (w_msd_disp != MSD_TOP) && (w_idx4 == w_msd_disp + 4'd1);
    assign w_visible  = w_is_minus || (r_idx == '0) || !r_disp_blank || (w_idx4 <= w_msd_disp);

    always_comb begin
        w_anode_d   = AN_OFF;
        w_segment_d = SEG_INACT;
        if (r_state == ST_BLANK && w_visible) begin
            w_anode_d   = (DIGITS'(1) << r_idx) ^ AN_OFF;
            w_segment_d = (w_is_minus ? SEG_MINUS : w_dec) ^ SEG_INACT;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_anode      <= AN_OFF;
            r_segment    <= SEG_INACT;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (w_tick) begin
                r_anode   <= w_anode_d;
                r_segment <= w_segment_d;
            end
        end
    end

    // A load landing on the wrap cycle stays pending: the copy reads the old buffer
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_pend_val   <= '0;
            r_pend_neg   <= 1'b0;
            r_pend_blank <= 1'b0;
            r_pend_flag  <= 1'b0;
            r_disp_val   <= '0;
            r_disp_neg   <= 1'b0;
            r_disp_blank <= 1'b0;
            r_load_ack   <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_load_ack <= 1'b0;
            if (w_wrap && r_pend_flag) begin
                r_disp_val   <= r_pend_val;
                r_disp_neg   <= r_pend_neg;
                r_disp_blank <= r_pend_blank;
                r_pend_flag  <= 1'b0;
                r_load_ack   <= 1'b1;
                r_overflow   <= r_pend_neg && (w_msd_pend == MSD_TOP);
            end
            if (load) begin
                r_pend_val   <= value_in;
                r_pend_neg   <= negative;
                r_pend_blank <= blank_zeros;
                r_pend_flag  <= 1'b1;
            end
        end
    end

    assign anode      = r_anode;
    assign segment    = r_segment;
    assign load_ack   = r_load_ack;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_display_scanner.sv
// Randomised bench for display_scanner against a tick-level reference model.
module tb_display_scanner;

    logic        clk = 1'b0;
    logic        reset, scan_clk, load, negative, blank_zeros;
    logic [15:0] value_in;
    logic        load_ack, frame_done, overflow;
    logic [3:0]  anode;
    logic [6:0]  segment;

    display_scanner #(.DIGITS(4), .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)) dut (
        .clock_in    (clk),
        .reset       (reset),
        .scan_clk    (scan_clk),
        .value_in    (value_in),
        .negative    (negative),
        .blank_zeros (blank_zeros),
        .load        (load),
        .load_ack    (load_ack),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .anode       (anode),
        .segment     (segment)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse counters; a pulse stretched to two cycles counts twice
    int ack_cnt = 0;
    int fd_cnt  = 0;
    always @(negedge clk) begin
        ack_cnt += int'(load_ack);
        fd_cnt  += int'(frame_done);
    end

    // Reference model: tick count since reset, pending and displayed values
    logic [6:0]  hexp [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          m_ticks, m_ack = 0, m_fd = 0;
    logic [15:0] m_pv, m_dv;
    logic        m_pn, m_pb, m_pf, m_dn, m_db, m_ovf;

    function automatic void m_reset();
        m_ticks = 0; m_pv = 0; m_dv = 0;
        m_pn = 0; m_pb = 0; m_pf = 0; m_dn = 0; m_db = 0; m_ovf = 0;
    endfunction

    function automatic void m_load(input logic [15:0] v, input logic n, input logic b);
        m_pv = v; m_pn = n; m_pb = b; m_pf = 1;
    endfunction

    // Tick k (k>=1) is slot (k-1)%8 of the frame: even slots show digit slot/2,
    // odd slots are the dark gap; slot 7 ends the frame.
    function automatic void m_tick();
        m_ticks++;
        if ((m_ticks - 1) % 8 == 7) begin
            m_fd++;
            if (m_pf) begin
                m_dv = m_pv; m_dn = m_pn; m_db = m_pb; m_pf = 0;
                m_ack++;
                m_ovf = m_pn && (m_pv[15:12] != 4'd0);
            end
        end
    endfunction

    function automatic void exp_out(output logic [3:0] an, output logic [6:0] sg);
        int p, d, msd;
        logic [3:0] nib;
        an = 4'hF;
        sg = 7'h7F;
        if (m_ticks == 0) return;
        p = (m_ticks - 1) % 8;
        if (p % 2 != 0) return;
        d = p / 2;
        msd = 0;
        for (int i = 3; i >= 0; i--) begin
            if (m_dv[4*i +: 4] != 4'd0) begin
                msd = i;
                break;
            end
        end
        if (m_dn && msd < 3 && d == msd + 1) begin
            an = ~(4'b0001 << d);
            sg = ~7'h40;
        end else if (d == 0 || !m_db || d <= msd) begin
            nib = m_dv[4*d +: 4];
            an = ~(4'b0001 << d);
            sg = ~hexp[nib];
        end
    endfunction

    task automatic check_all(input string tag);
        logic [3:0] ea;
        logic [6:0] es;
        exp_out(ea, es);
        chk({tag, ".anode"}, 32'(anode), 32'(ea));
        chk({tag, ".segment"}, 32'(segment), 32'(es));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".load_ack"}, 32'(ack_cnt), 32'(m_ack));
        chk({tag, ".frame_done"}, 32'(fd_cnt), 32'(m_fd));
    endtask

    // One scan_clk period (20 clocks). mode: 0 no load, 1 load before the tick,
    // 2 load in the tick cycle itself, 3 load after the tick.
    task automatic step(input int mode, input logic [15:0] v, input logic n,
                        input logic b, input string tag);
        value_in = v; negative = n; blank_zeros = b;
        for (int c = 0; c < 20; c++) begin
            scan_clk = (c < 10);
            load = (mode == 1 && c == 0) || (mode == 2 && c == 2) || (mode == 3 && c == 12);
            @(negedge clk);
        end
        load = 1'b0;
        if (mode == 1) m_load(v, n, b);
        m_tick();
        if (mode >= 2) m_load(v, n, b);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(negedge clk);
        m_reset();
        check_all(tag);
        chk({tag, ".ack_level"}, 32'(load_ack), 32'd0);
        reset = 1'b0;
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 16'h0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        reset = 1'b1; scan_clk = 1'b0; load = 1'b0;
        negative = 1'b0; blank_zeros = 1'b0; value_in = 16'h0;
        m_reset();
        repeat (3) @(negedge clk);
        do_reset("reset");

        step(0, 16'h0, 1'b0, 1'b0, "first_show");
        chk("first_show.seg0", 32'(segment), 32'h40);
        run(7, "zero_frame");

        step(1, 16'h0A3F, 1'b0, 1'b1, "load_0A3F");
        run(16, "show_0A3F");

        step(1, 16'h0012, 1'b1, 1'b1, "load_neg12");
        run(16, "show_neg12");

        step(1, 16'h1234, 1'b1, 1'b0, "load_neg1234");
        run(16, "show_neg1234");

        step(1, 16'h0001, 1'b0, 1'b1, "dbl_a");
        step(0, 16'h0, 1'b0, 1'b0, "dbl_gap");
        step(1, 16'h0002, 1'b0, 1'b1, "dbl_b");
        run(12, "dbl_show");

        while (m_ticks % 8 != 7) step(0, 16'h0, 1'b0, 1'b0, "align");
        step(2, 16'h00C5, 1'b0, 1'b1, "coinc_idle");
        run(16, "coinc_idle_show");

        step(1, 16'h0B0D, 1'b0, 1'b0, "coinc_pend_a");
        while (m_ticks % 8 != 7) step(0, 16'h0, 1'b0, 1'b0, "align2");
        step(2, 16'h0E00, 1'b1, 1'b1, "coinc_pend_b");
        run(16, "coinc_pend_show");

        // Stalled scan_clk, low then high: at most the one rising edge ticks
        repeat (60) @(negedge clk);
        check_all("hold_low");
        scan_clk = 1'b1;
        repeat (60) @(negedge clk);
        m_tick();
        check_all("hold_high");
        scan_clk = 1'b0;
        repeat (20) @(negedge clk);
        check_all("hold_fall");

        while (!(m_ticks > 0 && (m_ticks - 1) % 8 == 4)) step(0, 16'h0, 1'b0, 1'b0, "to_digit2");
        do_reset("mid_reset");
        run(3, "after_reset");

        for (int i = 0; i < 160; i++) begin
            int mode;
            mode = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            step(mode, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
            if ($urandom_range(0, 3) == 0)
                step(1, 16'($urandom_range(0, 255)), 1'b1, 1'b1, "rand_small");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
